// File: rtl/mem_pkg.sv
// Shared constants and types for the pipelined memory responder and its
// word array.
package mem_pkg;

  localparam int MEM_LATENCY_DEFAULT    = 4;
  localparam int MEM_DEPTH_LOG2_DEFAULT = 10;
  localparam int MEM_WORD_W             = 16;
  localparam int MEM_ADDR_W             = 16;
  localparam int MEM_PEND_W             = 4;

  typedef struct packed {
    logic                  valid;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_WORD_W-1:0] data;
  } mem_resp_t;

  // A read accepted in the same cycle one is returned leaves the count unchanged.
  function automatic logic [MEM_PEND_W-1:0] pend_next(
    input logic [MEM_PEND_W-1:0] cur,
    input logic                  inc,
    input logic                  dec
  );
    logic [MEM_PEND_W-1:0] nxt;
    nxt = cur;
    case ({inc, dec})
      2'b10:   nxt = cur + MEM_PEND_W'(1);
      2'b01:   nxt = cur - MEM_PEND_W'(1);
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word storage with synchronous write and registered read; the
// read register is the first stage of the responder's delay line.
module mem_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_wr,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [MEM_WORD_W-1:0] i_wdata,
  output logic [MEM_WORD_W-1:0] o_rdata
);

  logic [MEM_WORD_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [MEM_WORD_W-1:0] r_rdata;
  logic                  w_wr_req;
  logic                  w_rd_req;

  assign w_wr_req = i_rst_n & i_en & i_wr;
  assign w_rd_req = i_rst_n & i_en & ~i_wr;

  // Storage is never cleared; a request seen during reset must not touch it.
  always_ff @(posedge i_clk) begin
    if (w_wr_req) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (w_rd_req) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_multicycle.sv
// Fully pipelined memory responder: one request per cycle, reads returned in
// order exactly LATENCY cycles later with an address tag.
module mem_multicycle
  import mem_pkg::*;
#(
  parameter int LATENCY    = MEM_LATENCY_DEFAULT,
  parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_wr,
  input  logic [MEM_ADDR_W-1:0] i_addr,
  input  logic [MEM_WORD_W-1:0] i_data_in,
  output logic [MEM_WORD_W-1:0] o_data_out,
  output logic                  o_data_valid,
  output logic [MEM_ADDR_W-1:0] o_data_addr,
  output logic [MEM_PEND_W-1:0] o_pending
);

  logic                  w_rd_accept;
  logic [DEPTH_LOG2-1:0] w_word_idx;
  logic [MEM_WORD_W-1:0] w_rdata;
  logic                  r_s1_valid;
  logic [MEM_ADDR_W-1:0] r_s1_addr;
  logic [MEM_PEND_W-1:0] r_pending;
  mem_resp_t             w_s1;
  mem_resp_t             w_out;

  assign w_rd_accept = i_rst_n & i_enable & ~i_wr;
  assign w_word_idx  = i_addr[DEPTH_LOG2:1];

  mem_word_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_enable),
    .i_wr   (i_wr),
    .i_idx  (w_word_idx),
    .i_wdata(i_data_in),
    .o_rdata(w_rdata)
  );

  // Stage-1 valid and tag ride alongside the array's registered read data.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_s1_addr <= i_addr;
      end
    end
  end

  assign w_s1 = '{valid: r_s1_valid, addr: r_s1_addr, data: w_rdata};

  generate
    if (LATENCY == 1) begin : g_lat1
      assign w_out = w_s1;
    end else begin : g_tail
      mem_resp_t r_tail [LATENCY-1];
      mem_resp_t w_prev [LATENCY-1];

      always_comb begin
        w_prev[0] = w_s1;
        for (int i = 1; i < LATENCY-1; i++) begin
          w_prev[i] = r_tail[i-1];
        end
      end

      // Payload moves only with a valid entry, so the outputs hold between responses.
      always_ff @(posedge i_clk) begin
        for (int i = 0; i < LATENCY-1; i++) begin
          if (!i_rst_n) begin
            r_tail[i] <= '0;
          end else begin
            r_tail[i].valid <= w_prev[i].valid;
            if (w_prev[i].valid) begin
              r_tail[i].addr <= w_prev[i].addr;
              r_tail[i].data <= w_prev[i].data;
            end
          end
        end
      end

      assign w_out = r_tail[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= pend_next(r_pending, w_rd_accept, w_out.valid);
    end
  end

  assign o_data_out   = w_out.data;
  assign o_data_valid = w_out.valid;
  assign o_data_addr  = w_out.addr;
  assign o_pending    = r_pending;

endmodule

// File: tb/tb_mem_multicycle.sv
// Drives a LATENCY=4 and a LATENCY=1 responder in lockstep and compares both
// against a queue-of-responses model built from the read/write rules.
module tb_mem_multicycle;

  localparam int LAT_A      = 4;
  localparam int LAT_B      = 1;
  localparam int DEPTH_LOG2 = 10;

  logic        clk = 1'b0;
  logic        rstN, en, wr;
  logic [15:0] addr, dataIn;
  logic [15:0] aOut, aAddr, bOut, bAddr;
  logic        aValid, bValid;
  logic [3:0]  aPend, bPend;

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [15:0] data;
  } resp_t;

  logic [15:0] memModel [int];
  resp_t       qA[$];
  resp_t       qB[$];
  int          cyc = 0;
  logic [15:0] eaData = '0, eaAddr = '0, ebData = '0, ebAddr = '0;
  logic [36:0] expA, expB;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mem_multicycle #(.LATENCY(LAT_A), .DEPTH_LOG2(DEPTH_LOG2)) u_dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_enable(en), .i_wr(wr), .i_addr(addr),
    .i_data_in(dataIn), .o_data_out(aOut), .o_data_valid(aValid),
    .o_data_addr(aAddr), .o_pending(aPend)
  );

  mem_multicycle #(.LATENCY(LAT_B), .DEPTH_LOG2(DEPTH_LOG2)) u_dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_enable(en), .i_wr(wr), .i_addr(addr),
    .i_data_in(dataIn), .o_data_out(bOut), .o_data_valid(bValid),
    .o_data_addr(bAddr), .o_pending(bPend)
  );

  // One clock of stimulus; the model predicts what both builds show next cycle.
  task automatic tick(input logic r, input logic e, input logic w,
                      input logic [15:0] a, input logic [15:0] d);
    int    idx;
    resp_t t;
    logic  va, vb;
    rstN = r; en = e; wr = w; addr = a; dataIn = d;
    @(posedge clk);
    idx = int'(a[DEPTH_LOG2:1]);
    if (!r) begin
      qA.delete(); qB.delete();
      eaData = '0; eaAddr = '0; ebData = '0; ebAddr = '0;
    end else if (e && w) begin
      memModel[idx] = d;
    end else if (e) begin
      t.addr = a;
      t.data = memModel.exists(idx) ? memModel[idx] : 16'h0000;
      t.due  = cyc + LAT_A; qA.push_back(t);
      t.due  = cyc + LAT_B; qB.push_back(t);
    end
    cyc++;
    while (qA.size() > 0 && qA[0].due < cyc) void'(qA.pop_front());
    while (qB.size() > 0 && qB[0].due < cyc) void'(qB.pop_front());
    va = (qA.size() > 0) && (qA[0].due == cyc);
    vb = (qB.size() > 0) && (qB[0].due == cyc);
    if (va) begin eaData = qA[0].data; eaAddr = qA[0].addr; end
    if (vb) begin ebData = qB[0].data; ebAddr = qB[0].addr; end
    expA = {va, 4'(qA.size()), eaData, eaAddr};
    expB = {vb, 4'(qB.size()), ebData, ebAddr};
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    checks++;
    if ({aValid, aPend, aOut, aAddr} !== 37'h0) begin
      errors++;
      $display("[TB] FAIL reset_A: got %h want 0 (valid,pending,data,addr)", {aValid, aPend, aOut, aAddr});
    end
    checks++;
    if ({bValid, bPend, bOut, bAddr} !== 37'h0) begin
      errors++;
      $display("[TB] FAIL reset_B: got %h want 0 (valid,pending,data,addr)", {bValid, bPend, bOut, bAddr});
    end
    tick(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_read_after_write();
    int          firstSeen = -1;
    int          nValid = 0;
    logic [15:0] gotData = '0, gotAddr = '0;
    tick(1'b1, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    tick(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    for (int c = 2; c <= 9; c++) begin
      checks++;
      if ({aValid, aPend, aOut, aAddr} !== expA) begin
        errors++;
        $display("[TB] FAIL raw_A c%0d: got %h want %h", c, {aValid, aPend, aOut, aAddr}, expA);
      end
      if (aValid === 1'b1) begin
        nValid++;
        if (firstSeen < 0) firstSeen = c;
        gotData = aOut; gotAddr = aAddr;
      end
      tick(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    checks++;
    if (firstSeen != 5 || nValid != 1) begin
      errors++;
      $display("[TB] FAIL raw_timing: got first=%0d count=%0d want first=5 count=1", firstSeen, nValid);
    end
    checks++;
    if ({gotData, gotAddr} !== {16'hBEEF, 16'h0010}) begin
      errors++;
      $display("[TB] FAIL raw_data: got %h/%h want beef/0010", gotData, gotAddr);
    end
  endtask

  task automatic test_in_order();
    logic [15:0] got[$];
    logic [15:0] want [4];
    int          peak = 0;
    want[0] = 16'h1111; want[1] = 16'h2222; want[2] = 16'h3333; want[3] = 16'h4444;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, 16'(2 * i), 16'h1111 * 16'(i + 1));
    for (int i = 0; i < 12; i++) begin
      if (i < 4) tick(1'b1, 1'b1, 1'b0, 16'(2 * i), 16'h0);
      else       tick(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      checks++;
      if ({aValid, aPend, aOut, aAddr} !== expA) begin
        errors++;
        $display("[TB] FAIL inorder_A i%0d: got %h want %h", i, {aValid, aPend, aOut, aAddr}, expA);
      end
      if (aValid === 1'b1) got.push_back(aOut);
      if (int'(aPend) > peak) peak = int'(aPend);
    end
    checks++;
    if (got.size() != 4 || peak != 4) begin
      errors++;
      $display("[TB] FAIL inorder_count: got responses=%0d peak=%0d want 4/4", got.size(), peak);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== want[i]) begin
        errors++;
        $display("[TB] FAIL inorder_data%0d: got %h want %h", i, (i < got.size()) ? got[i] : 16'h0, want[i]);
      end
    end
  endtask

  task automatic test_write_after_read();
    logic [15:0] got[$];
    int          at[$];
    tick(1'b1, 1'b1, 1'b1, 16'h0020, 16'hAAAA);
    for (int c = 0; c < 10; c++) begin
      if (c == 0 || c == 2) tick(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
      else if (c == 1)      tick(1'b1, 1'b1, 1'b1, 16'h0020, 16'h5555);
      else                  tick(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      checks++;
      if ({aValid, aPend, aOut, aAddr} !== expA) begin
        errors++;
        $display("[TB] FAIL war_A c%0d: got %h want %h", c + 1, {aValid, aPend, aOut, aAddr}, expA);
      end
      if (aValid === 1'b1) begin got.push_back(aOut); at.push_back(c + 1); end
    end
    checks++;
    if (got.size() != 2 || got[0] !== 16'hAAAA || got[1] !== 16'h5555 || at[0] != 4 || at[1] != 6) begin
      errors++;
      $display("[TB] FAIL war_order: got n=%0d %h@%0d %h@%0d want aaaa@4 5555@6", got.size(),
               (got.size() > 0) ? got[0] : 16'h0, (at.size() > 0) ? at[0] : -1,
               (got.size() > 1) ? got[1] : 16'h0, (at.size() > 1) ? at[1] : -1);
    end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] got[$];
    logic [15:0] gotAddr = '0;
    tick(1'b1, 1'b1, 1'b1, 16'h0030, 16'h7777);
    tick(1'b1, 1'b1, 1'b1, 16'h0032, 16'h0101);
    tick(1'b1, 1'b1, 1'b1, 16'h0034, 16'h0202);
    tick(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0);
    tick(1'b1, 1'b1, 1'b0, 16'h0032, 16'h0);
    tick(1'b1, 1'b1, 1'b0, 16'h0034, 16'h0);
    tick(1'b0, 1'b1, 1'b1, 16'h0030, 16'h1234);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (aValid !== 1'b0 || aPend !== 4'd0) begin
        errors++;
        $display("[TB] FAIL flush_A c%0d: got valid=%0b pending=%0d want 0/0", c, aValid, aPend);
      end
      checks++;
      if ({bValid, bPend, bOut, bAddr} !== expB) begin
        errors++;
        $display("[TB] FAIL flush_B c%0d: got %h want %h", c, {bValid, bPend, bOut, bAddr}, expB);
      end
      tick(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    tick(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0);
    for (int c = 0; c < 6; c++) begin
      if (aValid === 1'b1) begin got.push_back(aOut); gotAddr = aAddr; end
      tick(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    checks++;
    if (got.size() != 1 || got[0] !== 16'h7777 || gotAddr !== 16'h0030) begin
      errors++;
      $display("[TB] FAIL flush_keep: got n=%0d data=%h addr=%h want 1/7777/0030", got.size(),
               (got.size() > 0) ? got[0] : 16'h0, gotAddr);
    end
  endtask

  task automatic test_alias();
    logic [15:0] gotD[$];
    logic [15:0] gotA[$];
    tick(1'b1, 1'b1, 1'b1, 16'h0801, 16'h0F0F);
    tick(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0);
    tick(1'b1, 1'b1, 1'b0, 16'hF800, 16'h0);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({aValid, aPend, aOut, aAddr} !== expA) begin
        errors++;
        $display("[TB] FAIL alias_A c%0d: got %h want %h", c, {aValid, aPend, aOut, aAddr}, expA);
      end
      if (aValid === 1'b1) begin gotD.push_back(aOut); gotA.push_back(aAddr); end
      tick(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    checks++;
    if (gotD.size() != 2 || gotD[0] !== 16'h0F0F || gotA[0] !== 16'h0000 ||
        gotD[1] !== 16'h0F0F || gotA[1] !== 16'hF800) begin
      errors++;
      $display("[TB] FAIL alias_data: got n=%0d first=%h@%h want 2 responses 0f0f@0000 then 0f0f@f800",
               gotD.size(), (gotD.size() > 0) ? gotD[0] : 16'h0, (gotA.size() > 0) ? gotA[0] : 16'h0);
    end
  endtask

  task automatic test_latency1();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tick(1'b1, 1'b1, 1'b0, 16'(2 * (i % 4)), 16'h0);
      else       tick(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      checks++;
      if ({bValid, bPend, bOut, bAddr} !== expB) begin
        errors++;
        $display("[TB] FAIL lat1_B i%0d: got %h want %h", i, {bValid, bPend, bOut, bAddr}, expB);
      end
      checks++;
      if (bValid !== (i < 8) || bPend > 4'd1) begin
        errors++;
        $display("[TB] FAIL lat1_stream i%0d: got valid=%0b pending=%0d want valid=%0b pending<=1",
                 i, bValid, bPend, (i < 8));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 64; k < 80; k++) tick(1'b1, 1'b1, 1'b1, 16'(k << 1), 16'($urandom));
    for (int c = 0; c < 300; c++) begin
      int          idx;
      logic [15:0] a;
      idx = $urandom_range(64, 79);
      a   = (16'($urandom) & 16'hF801) | 16'(idx << 1);
      tick(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), a, 16'($urandom));
      checks++;
      if ({aValid, aPend, aOut, aAddr} !== expA) begin
        errors++;
        $display("[TB] FAIL rand_A c%0d: got %h want %h", c, {aValid, aPend, aOut, aAddr}, expA);
      end
      checks++;
      if ({bValid, bPend, bOut, bAddr} !== expB) begin
        errors++;
        $display("[TB] FAIL rand_B c%0d: got %h want %h", c, {bValid, bPend, bOut, bAddr}, expB);
      end
    end
  endtask

  initial begin
    rstN = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; dataIn = '0;
    @(negedge clk);
    test_reset();
    test_read_after_write();
    test_in_order();
    test_write_after_read();
    test_reset_midflight();
    test_alias();
    test_latency1();
    test_random();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
